// File: rtl/t05_pkg.sv
// Shared types and defaults for the SRAM client arbiter.
package t05_pkg;

  localparam int unsigned DefNumCh   = 4;
  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefTimeout = 255;

  localparam bit ARB_FIXED = 1'b0;
  localparam bit ARB_RR    = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp
  } arb_state_t;

endpackage

// File: rtl/t05_rr_picker.sv
// Combinational winner selection: round-robin above last_i, or lowest index in fixed mode.
module t05_rr_picker #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] last_i,
  input  logic                      rr_en_i,
  output logic [NUM_CH-1:0]         grant_o,
  output logic [$clog2(NUM_CH)-1:0] index_o,
  output logic                      valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // Round-robin scans upward from the slot just after the previous winner.
      cand = rr_en_i ? IdxW'((32'(last_i) + 32'd1 + i) % NUM_CH) : IdxW'(i);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        index_o       = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// N-channel arbiter in front of the wishbone manager CPU port, with per-channel
// completion/timeout pulses and a captured read-data register.
module t05_sram_arbiter
  import t05_pkg::*;
#(
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter bit          RR_MODE = ARB_RR,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              req_i,
  input  logic [NUM_CH-1:0]              we_i,
  input  logic [NUM_CH*ADDR_W-1:0]       addr_i,
  input  logic [NUM_CH*DATA_W-1:0]       wdata_i,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   sel_i,
  output logic [NUM_CH-1:0]              gnt_o,
  output logic [NUM_CH-1:0]              done_o,
  output logic [NUM_CH-1:0]              err_o,
  output logic [DATA_W-1:0]              rdata_o,
  output logic                           wm_write_o,
  output logic                           wm_read_o,
  output logic [ADDR_W-1:0]              wm_addr_o,
  output logic [DATA_W/8-1:0]            wm_sel_o,
  output logic [DATA_W-1:0]              wm_wdata_o,
  input  logic [DATA_W-1:0]              wm_rdata_i,
  input  logic                           wm_busy_i
);

  localparam int unsigned SelW = DATA_W / 8;
  localparam int unsigned IdxW = $clog2(NUM_CH);

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];
  logic [SelW-1:0]   sel_arr   [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = wdata_i[k*DATA_W +: DATA_W];
    assign sel_arr[k]   = sel_i[k*SelW +: SelW];
  end

  arb_state_t        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic              wr_q, wr_d, rd_q, rd_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]   last_q, last_d;

  logic [NUM_CH-1:0] pick_grant;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;
  logic [16:0]       cnt_inc;
  logic              timeout_hit;

  t05_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i   (req_i),
    .last_i  (last_q),
    .rr_en_i (RR_MODE == ARB_RR),
    .grant_o (pick_grant),
    .index_o (pick_idx),
    .valid_o (pick_valid)
  );

  assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
  assign timeout_hit = cnt_inc >= 17'(TIMEOUT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_grant;
          we_d    = we_i[pick_idx];
          wr_d    = we_i[pick_idx];
          rd_d    = !we_i[pick_idx];
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          sel_d   = sel_arr[pick_idx];
          last_d  = pick_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        cnt_d = cnt_inc[15:0];
        if (timeout_hit) begin
          err_d   = gnt_q;
          state_d = StResp;
        end else if (wm_busy_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        cnt_d = cnt_inc[15:0];
        // Busy falling wins over a timeout reached in the same cycle.
        if (!wm_busy_i) begin
          done_d = gnt_q;
          if (!we_q) rdata_d = wm_rdata_i;
          state_d = StResp;
        end else if (timeout_hit) begin
          err_d   = gnt_q;
          state_d = StResp;
        end
      end
      StResp: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= IdxW'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign wm_write_o = wr_q;
  assign wm_read_o  = rd_q;
  assign wm_addr_o  = addr_q;
  assign wm_sel_o   = sel_q;
  assign wm_wdata_o = wdata_q;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter in lockstep from shared stimulus and
// checks both against a transaction-level model of grant order, timing and read capture.
module tb_t05_sram_arbiter;

  localparam int unsigned NCh = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCh-1:0] req, we;
  logic [31:0]    addr_a  [NCh];
  logic [31:0]    wdata_a [NCh];
  logic [3:0]     sel_a   [NCh];
  logic [NCh*32-1:0] addr_p, wdata_p;
  logic [NCh*4-1:0]  sel_p;
  logic [31:0] wm_rdata;
  logic        wm_busy;

  logic [NCh-1:0] r_gnt, r_done, r_err, f_gnt, f_done, f_err;
  logic [31:0]    r_rdata, r_addr, r_wdata, f_rdata, f_addr, f_wdata;
  logic [3:0]     r_sel, f_sel;
  logic           r_wr, r_rd, f_wr, f_rd;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int          last_rr;
  logic [31:0] exp_rd_r, exp_rd_f;

  always #5 clk = ~clk;

  always_comb begin
    addr_p  = '0;
    wdata_p = '0;
    sel_p   = '0;
    for (int k = 0; k < NCh; k++) begin
      addr_p[k*32 +: 32] = addr_a[k];
      wdata_p[k*32 +: 32] = wdata_a[k];
      sel_p[k*4 +: 4]     = sel_a[k];
    end
  end

  t05_sram_arbiter #(
    .NUM_CH (NCh), .ADDR_W (32), .DATA_W (32), .RR_MODE (1'b1), .TIMEOUT (8)
  ) u_dut_rr (
    .clk (clk), .rst_n (rst_n), .req_i (req), .we_i (we), .addr_i (addr_p),
    .wdata_i (wdata_p), .sel_i (sel_p), .gnt_o (r_gnt), .done_o (r_done), .err_o (r_err),
    .rdata_o (r_rdata), .wm_write_o (r_wr), .wm_read_o (r_rd), .wm_addr_o (r_addr),
    .wm_sel_o (r_sel), .wm_wdata_o (r_wdata), .wm_rdata_i (wm_rdata), .wm_busy_i (wm_busy)
  );

  t05_sram_arbiter #(
    .NUM_CH (NCh), .ADDR_W (32), .DATA_W (32), .RR_MODE (1'b0), .TIMEOUT (8)
  ) u_dut_fx (
    .clk (clk), .rst_n (rst_n), .req_i (req), .we_i (we), .addr_i (addr_p),
    .wdata_i (wdata_p), .sel_i (sel_p), .gnt_o (f_gnt), .done_o (f_done), .err_o (f_err),
    .rdata_o (f_rdata), .wm_write_o (f_wr), .wm_read_o (f_rd), .wm_addr_o (f_addr),
    .wm_sel_o (f_sel), .wm_wdata_o (f_wdata), .wm_rdata_i (wm_rdata), .wm_busy_i (wm_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input bit rr, input int last);
    for (int i = 1; i <= NCh; i++) begin
      int k = rr ? (last + i) % NCh : i - 1;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic rand_fields();
    for (int k = 0; k < NCh; k++) begin
      addr_a[k]  = $urandom;
      wdata_a[k] = $urandom;
      sel_a[k]   = 4'($urandom);
    end
  endtask

  task automatic check_idle();
    check_eq("idle_rr", {r_gnt, r_done, r_err, r_wr, r_rd}, 64'd0);
    check_eq("idle_fx", {f_gnt, f_done, f_err, f_wr, f_rd}, 64'd0);
    check_eq("rdata_idle_rr", r_rdata, exp_rd_r);
    check_eq("rdata_idle_fx", f_rdata, exp_rd_f);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctl_rr"}, {r_gnt, r_done, r_err, r_wr, r_rd}, 64'd0);
    check_eq({tag, "_ctl_fx"}, {f_gnt, f_done, f_err, f_wr, f_rd}, 64'd0);
    check_eq({tag, "_addr"}, {r_addr, f_addr}, 64'd0);
    check_eq({tag, "_wdata"}, {r_wdata, f_wdata}, 64'd0);
    check_eq({tag, "_rdata"}, {r_rdata, f_rdata}, 64'd0);
    check_eq({tag, "_sel"}, {r_sel, f_sel}, 64'd0);
  endtask

  // One transaction from an idle cycle: b = cycles the manager stays busy (0 = never).
  task automatic run_txn(input logic [3:0] r, input logic [3:0] w, input int b,
                         input bit fix_rv);
    int wr_i, wf_i, pulse;
    bit to_exp;
    logic [31:0] rv;
    logic [3:0] oh_r, oh_f;
    check_idle();
    req = r;
    we  = w;
    if (r == 4'b0) begin
      step();
      return;
    end
    wr_i = pick(r, 1'b1, last_rr);
    wf_i = pick(r, 1'b0, 0);
    last_rr = wr_i;
    oh_r = 4'b1 << wr_i;
    oh_f = 4'b1 << wf_i;
    step();
    check_eq("gnt_rr", r_gnt, oh_r);
    check_eq("gnt_fx", f_gnt, oh_f);
    check_eq("strobe_rr", {r_wr, r_rd}, {w[wr_i], ~w[wr_i]});
    check_eq("strobe_fx", {f_wr, f_rd}, {w[wf_i], ~w[wf_i]});
    check_eq("addr_rr", r_addr, addr_a[wr_i]);
    check_eq("addr_fx", f_addr, addr_a[wf_i]);
    check_eq("wdata_rr", r_wdata, wdata_a[wr_i]);
    check_eq("wdata_fx", f_wdata, wdata_a[wf_i]);
    check_eq("sel_rr", r_sel, sel_a[wr_i]);
    check_eq("sel_fx", f_sel, sel_a[wf_i]);
    // Fields were captured at acceptance; anything the clients do now must not matter.
    req = 4'($urandom);
    we  = 4'($urandom);
    rand_fields();
    to_exp = (b < 1) || (b > 7);
    pulse  = to_exp ? 10 : 3 + b;
    rv     = '0;
    for (int c = 2; c <= pulse; c++) begin
      step();
      if (c < pulse) begin
        check_eq("hold_rr", {r_gnt, r_done, r_err, r_wr, r_rd}, {oh_r, 10'd0});
        check_eq("hold_fx", {f_gnt, f_done, f_err, f_wr, f_rd}, {oh_f, 10'd0});
        check_eq("rdata_hold_rr", r_rdata, exp_rd_r);
        check_eq("rdata_hold_fx", f_rdata, exp_rd_f);
      end else begin
        if (!to_exp && !w[wr_i]) exp_rd_r = rv;
        if (!to_exp && !w[wf_i]) exp_rd_f = rv;
        check_eq("done_rr", r_done, to_exp ? 4'b0 : oh_r);
        check_eq("done_fx", f_done, to_exp ? 4'b0 : oh_f);
        check_eq("err_rr", r_err, to_exp ? oh_r : 4'b0);
        check_eq("err_fx", f_err, to_exp ? oh_f : 4'b0);
        check_eq("gnt_resp_rr", r_gnt, oh_r);
        check_eq("gnt_resp_fx", f_gnt, oh_f);
        check_eq("rdata_resp_rr", r_rdata, exp_rd_r);
        check_eq("rdata_resp_fx", f_rdata, exp_rd_f);
      end
      wm_busy  = (c < pulse) && (c <= 1 + b);
      wm_rdata = (fix_rv && c == 2 + b) ? 32'h1234_5678 : $urandom;
      if (c == 2 + b) rv = wm_rdata;
    end
    step();
  endtask

  task automatic reset_mid();
    check_idle();
    req = 4'hF;
    we  = 4'h0;
    step();
    step();
    wm_busy = 1'b1;
    step();
    check_eq("pre_rst_gnt", r_gnt, 4'b1 << pick(4'hF, 1'b1, last_rr));
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    step();
    step();
    check_reset("rst_hold");
    wm_busy = 1'b0;
    req     = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    step();
    last_rr  = NCh - 1;
    exp_rd_r = '0;
    exp_rd_f = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    we       = '0;
    wm_busy  = 1'b0;
    wm_rdata = '0;
    rand_fields();
    last_rr  = NCh - 1;
    exp_rd_r = '0;
    exp_rd_f = '0;
    #1 check_reset("reset");
    step();
    step();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single write by ch2, manager busy 3 cycles.
    addr_a[2]  = 32'h3300_0010;
    wdata_a[2] = 32'hDEAD_BEEF;
    sel_a[2]   = 4'hF;
    run_txn(4'b0100, 4'b0100, 3, 1'b0);
    // Read capture by ch0, then a ch1 write must leave it untouched.
    rand_fields();
    run_txn(4'b0001, 4'b0000, 2, 1'b1);
    rand_fields();
    run_txn(4'b0010, 4'b0010, 2, 1'b0);
    // All channels requesting: rotation vs. fixed priority.
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      run_txn(4'hF, 4'($urandom), $urandom_range(1, 4), 1'b0);
    end
    // ch1 and ch3 held: fixed priority starves ch3 until ch1 drops.
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      run_txn(4'b1010, 4'($urandom), 2, 1'b0);
    end
    rand_fields();
    run_txn(4'b1000, 4'($urandom), 2, 1'b0);
    // Timeout boundaries: never busy, stuck busy, busy falls at the limit, one past it.
    rand_fields();
    run_txn(4'b0110, 4'b0000, 0, 1'b0);
    rand_fields();
    run_txn(4'b0011, 4'b0000, 20, 1'b0);
    rand_fields();
    run_txn(4'b1001, 4'b0000, 7, 1'b0);
    rand_fields();
    run_txn(4'b0101, 4'b0000, 8, 1'b0);
    rand_fields();
    run_txn(4'b0001, 4'b0000, 1, 1'b0);
    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      rand_fields();
      run_txn(4'($urandom), 4'($urandom), $urandom_range(0, 10), 1'b0);
    end
    // Reset during WAIT_DONE, then ch0 must win first.
    reset_mid();
    rand_fields();
    run_txn(4'hF, 4'($urandom), 2, 1'b0);
    run_txn(4'h0, 4'h0, 0, 1'b0);
    check_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
